queue_reader: RTL and testbench

//  Drain-side controller for the byte queue. Pops a requested number of bytes

---
 rtl/queue_reader_if.sv | 22 ++
 rtl/queue_reader.sv | 140 ++++++++++++++
 tb/tb_queue_reader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/queue_reader_if.sv
// rtl/queue_reader_if.sv - queue read port and downstream byte stream seen by the reader
interface queue_reader_if #(
  parameter int DATA_W = 8
) ();
  logic              q_En_o;
  logic              q_RW_o;
  logic [DATA_W-1:0] q_data_i;
  logic              q_empty_i;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ready_i;

  modport master (
    output q_En_o, q_RW_o, m_valid_o, m_data_o,
    input  q_data_i, q_empty_i, m_ready_i
  );

  modport slave (
    input  q_En_o, q_RW_o, m_valid_o, m_data_o,
    output q_data_i, q_empty_i, m_ready_i
  );
endinterface

// File: rtl/queue_reader.sv
// rtl/queue_reader.sv - drains a byte queue into a valid/ready stream via a 2-entry buffer
module queue_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Start_i,
  input  logic [LEN_W-1:0] Len_i,
  input  logic             Abort_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic [LEN_W-1:0] Count_o,
  queue_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_e;

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic active;
  logic abort_hit;
  logic rd_en;
  logic pop;

  // Read strobe depends only on registered state and queue/abort inputs, never on m_ready_i.
  assign active    = (state_q == DRAIN) || (state_q == FLUSH);
  assign abort_hit = active && Abort_i;
  assign rd_en     = (state_q == DRAIN) && !bus.q_empty_i && (remaining_q != '0)
                     && (occ_q < 2'd2) && !Abort_i;
  assign pop       = (occ_q != 2'd0) && bus.m_ready_i;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    if (rd_en) begin
      remaining_d = remaining_q - ONE;
    end
    if (pop && (count_q != CNT_MAX)) begin
      count_d = count_q + ONE;
    end

    // Head always sits in buf0; buf1 only holds a byte while occ is 2.
    case (occ_q)
      2'd0: begin
        if (rd_en) begin
          buf0_d = bus.q_data_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (rd_en && pop) begin
          buf0_d = bus.q_data_i;
        end else if (rd_en) begin
          buf1_d = bus.q_data_i;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          buf0_d = buf1_q;
          occ_d  = 2'd1;
        end
      end
    endcase

    case (state_q)
      IDLE: begin
        if (Start_i) begin
          remaining_d = Len_i;
          count_d     = '0;
          state_d     = (Len_i != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (Abort_i) begin
          state_d = IDLE;
        end else if (remaining_d == '0) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (Abort_i) begin
          state_d = IDLE;
        end else if (occ_q == 2'd0) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_hit) begin
      occ_d = 2'd0;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign Busy_o        = active;
  assign Done_o        = (state_q == DONE);
  assign Count_o       = count_q;
  assign bus.q_En_o    = rd_en;
  assign bus.q_RW_o    = 1'b0;
  assign bus.m_valid_o = (occ_q != 2'd0);
  assign bus.m_data_o  = buf0_q;

endmodule

// File: tb/tb_queue_reader.sv
// tb/tb_queue_reader.sv - scoreboard bench for queue_reader with a byte-queue model
module tb_queue_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] count;

  queue_reader_if #(.DATA_W(8)) bus ();

  queue_reader #(.DATA_W(8), .LEN_W(8)) dut (
    .Clk_i   (clk),
    .Rst_i   (rst),
    .Start_i (start),
    .Len_i   (len),
    .Abort_i (abort),
    .Busy_o  (busy),
    .Done_o  (done),
    .Count_o (count),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] qmem[$];
  logic [7:0] exp_q[$];
  int         n_reads = 0;
  logic       en_s, done_s, vld_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic refresh();
    bus.q_empty_i = (qmem.size() == 0);
    bus.q_data_i  = (qmem.size() != 0) ? qmem[0] : 8'h00;
  endtask

  // One clock: sample just after the falling edge, let the rising edge act, model the queue pop.
  task automatic cyc();
    #1;
    en_s   = bus.q_En_o;
    done_s = done;
    vld_s  = bus.m_valid_o;
    if (bus.q_empty_i) check("en_while_empty", en_s, 0);
    @(posedge clk);
    if (en_s) begin
      void'(qmem.pop_front());
      n_reads++;
    end
    @(negedge clk);
    refresh();
  endtask

  task automatic start_xfer(input int l, input bit push_exp);
    len   = 8'(l);
    start = 1'b1;
    if (push_exp) for (int i = 0; i < l; i++) exp_q.push_back(qmem[i]);
    cyc();
    start = 1'b0;
  endtask

  task automatic run_done(input int budget, input bit rand_ready);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (rand_ready) bus.m_ready_i = 1'($urandom_range(0, 1));
      cyc();
      if (done_s) begin
        got = 1;
        break;
      end
    end
    check("done_within_budget", got, 1);
  endtask

  // Monitor: every downstream handshake must match the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_unexpected: got %0h expected no byte", bus.m_data_o);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", bus.m_data_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] en_tr, done_tr, vld_tr, first;
    bit         any;
    int         r0, l, extra;

    rst = 1'b1; start = 1'b0; abort = 1'b0; len = 8'd0;
    bus.m_ready_i = 1'b0;
    refresh();
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_count", count, 0);
    check("reset_en", bus.q_En_o, 0);
    check("reset_valid", bus.m_valid_o, 0);
    check("rw_tied_read", bus.q_RW_o, 0);

    // Streaming 11,22,33 with no backpressure, cycle 0 = Start.
    qmem = '{8'h11, 8'h22, 8'h33};
    refresh();
    bus.m_ready_i = 1'b1;
    en_tr = '0; done_tr = '0; vld_tr = '0;
    start_xfer(3, 1);
    en_tr[0] = en_s; done_tr[0] = done_s; vld_tr[0] = vld_s;
    for (int c = 1; c < 8; c++) begin
      cyc();
      en_tr[c] = en_s; done_tr[c] = done_s; vld_tr[c] = vld_s;
    end
    check("stream_en_cycles", en_tr, 8'b0000_1110);
    check("stream_valid_cycles", vld_tr, 8'b0001_1100);
    check("stream_done_cycle", done_tr, 8'b0100_0000);
    check("stream_count", count, 3);
    check("stream_all_out", exp_q.size(), 0);

    // Zero length completes immediately without reads.
    r0 = n_reads;
    qmem = '{8'h77};
    refresh();
    start_xfer(0, 1);
    cyc();
    check("len0_done_next", done_s, 1);
    check("len0_no_reads", n_reads - r0, 0);
    qmem.delete();
    refresh();

    // Backpressure: only two reads fit while stalled.
    for (int i = 0; i < 8; i++) qmem.push_back(8'($urandom));
    first = qmem[0];
    refresh();
    bus.m_ready_i = 1'b0;
    r0 = n_reads;
    start_xfer(8, 1);
    repeat (6) cyc();
    #1;
    check("bp_reads", n_reads - r0, 2);
    check("bp_en_low", bus.q_En_o, 0);
    check("bp_valid", bus.m_valid_o, 1);
    check("bp_head_held", bus.m_data_o, first);
    bus.m_ready_i = 1'b1;
    run_done(40, 0);
    check("bp_all_out", exp_q.size(), 0);
    check("bp_count", count, 8);

    // Empty queue stalls in DRAIN until a byte is written.
    qmem.delete();
    refresh();
    start_xfer(2, 0);
    any = 0;
    repeat (4) begin
      cyc();
      any |= en_s;
    end
    check("empty_no_reads", any, 0);
    #1;
    check("empty_busy", busy, 1);
    qmem.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    refresh();
    cyc();
    check("empty_read_a5", en_s, 1);
    #1;
    check("empty_a5_valid", bus.m_valid_o, 1);
    check("empty_a5_data", bus.m_data_o, 8'hA5);
    cyc();
    check("empty_single_read", en_s, 0);
    qmem.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    refresh();
    run_done(20, 0);
    check("empty_count", count, 2);

    // Abort once the buffer is full.
    for (int i = 0; i < 5; i++) qmem.push_back(8'($urandom));
    refresh();
    bus.m_ready_i = 1'b0;
    start_xfer(5, 0);
    cyc(); cyc();
    abort = 1'b1;
    #1;
    check("abort_full", bus.m_valid_o, 1);
    check("abort_en_low", bus.q_En_o, 0);
    cyc();
    abort = 1'b0;
    #1;
    check("abort_valid_cleared", bus.m_valid_o, 0);
    check("abort_busy_cleared", busy, 0);
    check("abort_count_kept", count, 0);
    any = 0;
    repeat (4) begin
      cyc();
      any |= done_s;
    end
    check("abort_no_done", any, 0);
    qmem.delete();
    refresh();

    // Reset mid-DRAIN with a full buffer.
    for (int i = 0; i < 6; i++) qmem.push_back(8'($urandom));
    refresh();
    start_xfer(6, 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_valid", bus.m_valid_o, 0);
    check("midreset_en", bus.q_En_o, 0);
    check("midreset_count", count, 0);
    qmem.delete();
    refresh();

    // Random transfers: output must equal the first Len bytes of the queue, in order.
    for (int t = 0; t < 25; t++) begin
      l     = $urandom_range(0, 12);
      extra = $urandom_range(0, 3);
      while (qmem.size() < l + extra) qmem.push_back(8'($urandom));
      refresh();
      bus.m_ready_i = 1'($urandom_range(0, 1));
      start_xfer(l, 1);
      run_done(200, 1);
      check("rand_count", count, l);
      check("rand_all_out", exp_q.size(), 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
